// File: rtl/mem_wb_stage.sv
// MEM stage with internal data RAM and MEM/WB register driving the writeback mux.
// Define MEM_SUBWORD_EN for byte/half accesses; otherwise every access is a word.
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int DMEM_AW = 8,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] rd,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [1:0]        size,
    input  logic              load_signed,
    output logic [DATA_W-1:0] outMuxWb,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              wb_valid,
    output logic              misalign_err,
    output logic [7:0]        err_count
);

    localparam int DEPTH = 1 << DMEM_AW;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DMEM_AW-1:0] idx;
    logic [DATA_W-1:0]  rword;
    logic [DATA_W-1:0]  wword;
    logic [DATA_W-1:0]  ldata;
    logic [DATA_W-1:0]  wrep;
    logic [NB-1:0]      wmask;
    logic               aligned;
    logic               mis;
    logic               accept;
    logic               do_wr;

    logic [DATA_W-1:0]  out_q, out_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic               we_q, we_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;

    logic unused_hi;
    assign unused_hi = ^alu_result[DATA_W-1:DMEM_AW+2];

    assign idx    = alu_result[DMEM_AW+1:2];
    assign rword  = mem_q[idx];
    assign accept = in_valid & ~stall & ~flush & ~reset;

`ifdef MEM_SUBWORD_EN
    logic [1:0]  lane;
    logic [7:0]  bsh;
    logic [15:0] hsh;

    assign lane = alu_result[1:0];
    assign bsh  = 8'(rword >> {lane, 3'b000});
    assign hsh  = 16'(rword >> {lane[1], 4'b0000});

    always_comb begin
        aligned = (lane == 2'b00);
        wmask   = '1;
        wrep    = store_data;
        ldata   = rword;
        unique case (1'b1)
            (size == 2'b00): begin
                aligned = 1'b1;
                wmask   = NB'(1) << lane;
                wrep    = {NB{store_data[7:0]}};
                ldata   = {{(DATA_W-8){load_signed & bsh[7]}}, bsh};
            end
            (size == 2'b01): begin
                aligned = ~lane[0];
                wmask   = NB'(3) << {lane[1], 1'b0};
                wrep    = {(NB/2){store_data[15:0]}};
                ldata   = {{(DATA_W-16){load_signed & hsh[15]}}, hsh};
            end
            default: begin
            end
        endcase
    end
`else
    logic unused_sub;
    assign unused_sub = ^{size, load_signed};

    assign aligned = (alu_result[1:0] == 2'b00);
    assign wmask   = '1;
    assign wrep    = store_data;
    assign ldata   = rword;
`endif

    // Only the selected lanes of the old word are replaced.
    always_comb begin
        wword = rword;
        for (int b = 0; b < NB; b++) begin
            if (wmask[b]) wword[8*b +: 8] = wrep[8*b +: 8];
        end
    end

    assign mis   = (mem_read | mem_write) & ~aligned;
    assign do_wr = accept & mem_write & aligned;

    always_comb begin
        out_d = out_q;
        rd_d  = rd_q;
        we_d  = we_q;
        vld_d = vld_q;
        err_d = err_q;
        cnt_d = cnt_q;
        if (flush || (!stall && !in_valid)) begin
            vld_d = 1'b0;
            we_d  = 1'b0;
            err_d = 1'b0;
        end else if (accept) begin
            out_d = mem_to_reg ? ldata : alu_result;
            rd_d  = rd;
            we_d  = reg_write & ~mem_write & ~mis;
            vld_d = 1'b1;
            err_d = mis;
            if (mis && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            rd_q  <= '0;
            we_q  <= 1'b0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            rd_q  <= rd_d;
            we_q  <= we_d;
            vld_q <= vld_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // RAM contents survive reset; accept already excludes the reset cycle.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[idx] <= wword;
    end

    assign outMuxWb     = out_q;
    assign wb_rd        = rd_q;
    assign wb_reg_write = we_q;
    assign wb_valid     = vld_q;
    assign misalign_err = err_q;
    assign err_count    = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage against a byte-array memory model.
module tb_mem_wb_stage;

    typedef struct {
        logic        rst, st, fl, v;
        logic [31:0] addr, sd;
        logic [4:0]  rd;
        logic        mr, mw, rw, m2r;
        logic [1:0]  sz;
        logic        ls;
    } op_t;

    typedef struct {
        logic [31:0] out;
        logic        known;
        logic [4:0]  rd;
        logic        we, valid, err;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [31:0] alu_result = '0, store_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        reg_write = 1'b0, mem_to_reg = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        load_signed = 1'b0;
    logic [31:0] outMuxWb;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, wb_valid, misalign_err;
    logic [7:0]  err_count;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t cur;
    logic [7:0] mb [1024];

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .rd(rd), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .size(size),
        .load_signed(load_signed), .outMuxWb(outMuxWb), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
        .misalign_err(misalign_err), .err_count(err_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic op_t nop();
        op_t o;
        o.rst = 0; o.st = 0; o.fl = 0; o.v = 0;
        o.addr = 0; o.sd = 0; o.rd = 0;
        o.mr = 0; o.mw = 0; o.rw = 0; o.m2r = 0;
        o.sz = 2'b10; o.ls = 0;
        return o;
    endfunction

    function automatic op_t st_op(input logic [31:0] a, d,
                                  input logic [1:0] sz);
        op_t o = nop();
        o.v = 1; o.addr = a; o.sd = d; o.mw = 1; o.sz = sz;
        return o;
    endfunction

    function automatic op_t ld_op(input logic [31:0] a, input logic [4:0] r,
                                  input logic [1:0] sz, input logic sg);
        op_t o = nop();
        o.v = 1; o.addr = a; o.rd = r; o.mr = 1; o.rw = 1; o.m2r = 1;
        o.sz = sz; o.ls = sg;
        return o;
    endfunction

    function automatic op_t alu_op(input logic [31:0] val,
                                   input logic [4:0] r);
        op_t o = nop();
        o.v = 1; o.addr = val; o.rd = r; o.rw = 1;
        return o;
    endfunction

    // Reference: little-endian byte memory, access width from size.
    task automatic model(input op_t o);
        int n, a;
        logic [31:0] v;
        logic al, mis;
        if (o.rst) begin
            cur.out = 0; cur.known = 1; cur.rd = 0; cur.we = 0;
            cur.valid = 0; cur.err = 0; cur.cnt = 0;
        end else if (o.fl || (!o.st && !o.v)) begin
            cur.valid = 0; cur.we = 0; cur.err = 0;
        end else if (o.v && !o.st) begin
`ifdef MEM_SUBWORD_EN
            n = (o.sz == 0) ? 1 : (o.sz == 1) ? 2 : 4;
`else
            n = 4;
`endif
            a = int'(o.addr % 1024);
            al = (o.addr % n) == 0;
            mis = (o.mr || o.mw) && !al;
            v = 0;
            for (int i = 0; i < n; i++)
                v = v | (32'(mb[(a + i) % 1024]) << (8 * i));
            if (o.ls && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
            if (o.ls && n == 2 && v[15]) v = v | 32'hFFFF_0000;
            if (o.mw && !mis)
                for (int i = 0; i < n; i++) mb[a + i] = o.sd[8*i +: 8];
            cur.valid = 1;
            cur.we = o.rw && !o.mw && !mis;
            cur.err = mis;
            if (mis && cur.cnt < 255) cur.cnt = cur.cnt + 1;
            cur.rd = o.rd;
            cur.out = o.m2r ? v : o.addr;
            cur.known = al && !o.mw;
        end
        q.push_back(cur);
    endtask

    task automatic issue(input op_t o);
        @(negedge clk);
        reset = o.rst; stall = o.st; flush = o.fl; in_valid = o.v;
        alu_result = o.addr; store_data = o.sd; rd = o.rd;
        mem_read = o.mr; mem_write = o.mw; reg_write = o.rw;
        mem_to_reg = o.m2r; size = o.sz; load_signed = o.ls;
        model(o);
    endtask

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wb_valid", 32'(wb_valid), 32'(e.valid));
                check("wb_reg_write", 32'(wb_reg_write), 32'(e.we));
                check("misalign_err", 32'(misalign_err), 32'(e.err));
                check("err_count", 32'(err_count), 32'(e.cnt));
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                if (e.known) check("outMuxWb", outMuxWb, e.out);
            end
        end
    end

    initial begin : stim
        op_t o;
        o = nop(); o.rst = 1;
        issue(o);
        issue(o);
        for (int i = 0; i < 256; i++) issue(st_op(32'(4 * i), $urandom, 2));
        issue(nop());

        issue(st_op(32'h10, 32'hDEAD_BEEF, 2));
        issue(ld_op(32'h10, 5'd5, 2, 0));
        post();
        check("ld_word_data", outMuxWb, 32'hDEAD_BEEF);
        check("ld_word_rd", 32'(wb_rd), 32'd5);
        check("ld_word_we", 32'(wb_reg_write), 32'd1);

        issue(alu_op(32'h1234, 5'd3));
        post();
        check("alu_data", outMuxWb, 32'h1234);
        issue(ld_op(32'h10, 5'd6, 2, 0));
        post();
        check("alu_ram_kept", outMuxWb, 32'hDEAD_BEEF);

        issue(ld_op(32'h22, 5'd7, 2, 0));
        post();
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_we", 32'(wb_reg_write), 32'd0);
        check("mis_cnt", 32'(err_count), 32'd1);
        issue(nop());
        post();
        check("mis_pulse", 32'(misalign_err), 32'd0);
        for (int i = 0; i < 299; i++) issue(ld_op(32'h22, 5'd7, 2, 0));
        post();
        check("mis_sat", 32'(err_count), 32'd255);

`ifdef MEM_SUBWORD_EN
        issue(st_op(32'h10, 32'h0, 2));
        issue(st_op(32'h13, 32'h80, 0));
        issue(ld_op(32'h10, 5'd1, 2, 0));
        post();
        check("sb_word", outMuxWb, 32'h8000_0000);
        issue(ld_op(32'h13, 5'd1, 0, 1));
        post();
        check("lb_signed", outMuxWb, 32'hFFFF_FF80);
        issue(ld_op(32'h12, 5'd2, 1, 0));
        post();
        check("lhu", outMuxWb, 32'h0000_8000);
`endif

        issue(st_op(32'h40, 32'h0BAD_F00D, 2));
        o = st_op(32'h40, 32'hA5A5_A5A5, 2); o.st = 1;
        repeat (3) issue(o);
        issue(ld_op(32'h40, 5'd9, 2, 0));
        post();
        check("stall_no_wr", outMuxWb, 32'h0BAD_F00D);
        issue(st_op(32'h40, 32'hA5A5_A5A5, 2));
        issue(ld_op(32'h40, 5'd9, 2, 0));
        post();
        check("stall_release", outMuxWb, 32'hA5A5_A5A5);

        o = st_op(32'h40, 32'h1234_5678, 2); o.fl = 1;
        issue(o);
        post();
        check("flush_valid", 32'(wb_valid), 32'd0);
        issue(ld_op(32'h40, 5'd9, 2, 0));
        post();
        check("flush_no_wr", outMuxWb, 32'hA5A5_A5A5);

        issue(st_op(32'h08, 32'h1122_3344, 2));
        o = st_op(32'h08, 32'hCAFE_F00D, 2); o.rst = 1;
        issue(o);
        post();
        check("rst_out", outMuxWb, 32'h0);
        check("rst_cnt", 32'(err_count), 32'd0);
        check("rst_valid", 32'(wb_valid), 32'd0);
        issue(ld_op(32'h08, 5'd4, 2, 0));
        post();
        check("rst_no_wr", outMuxWb, 32'h1122_3344);

        for (int i = 0; i < 800; i++) begin
            o = nop();
            o.rst = ($urandom_range(0, 99) == 0);
            o.st  = ($urandom_range(0, 5) == 0);
            o.fl  = ($urandom_range(0, 9) == 0);
            o.v   = ($urandom_range(0, 7) != 0);
            o.addr = $urandom;
            if ($urandom_range(0, 2) != 0) o.addr[1:0] = 2'b00;
            o.sd  = $urandom;
            o.rd  = 5'($urandom);
            o.mr  = 1'($urandom);
            o.mw  = 1'($urandom);
            o.rw  = 1'($urandom);
            o.m2r = 1'($urandom);
            o.sz  = 2'($urandom);
            o.ls  = 1'($urandom);
            issue(o);
        end
        issue(nop());

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 5-stage pipeline. It consumes the EX/MEM bundle, performs loads and stores on an internal data RAM, registers the result, and drives the writeback mux output outMuxWb.
- It also drives the write port of the register file.
- It sits between the EX/MEM register and the register file, directly upstream of the writeback path.

Parameters:
- DATA_W, 32, datapath width in bits.
- DMEM_AW, 8, data RAM word-address width (2^DMEM_AW words of DATA_W).
- REG_AW, 5, register-file index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold MEM/WB contents; the current input is not consumed.
- flush  in  1  replace the incoming op with a bubble.
- in_valid  in  1  EX/MEM slot holds a real instruction.
- alu_result  in  DATA_W  byte address for loads/stores; result for ALU ops.
- store_data  in  DATA_W  store operand (rt).
- rd  in  REG_AW  destination register.
- mem_read  in  1  load.
- mem_write  in  1  store.
- reg_write  in  1  instruction writes the register file.
- mem_to_reg  in  1  writeback select: 1 = load data, 0 = ALU result.
- size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- load_signed  in  1  sign-extend sub-word loads.
- outMuxWb  out  DATA_W  writeback mux output.
- wb_rd  out  REG_AW  registered rd.
- wb_reg_write  out  1  register-file write enable.
- wb_valid  out  1  MEM/WB slot valid.
- misalign_err  out  1  one-cycle pulse, registered with the faulting op.
- err_count  out  8  saturating count of misaligned accesses.

Behaviour:
- Reset (sync, highest priority):
  - Clear all MEM/WB fields: outMuxWb=0, wb_rd=0, wb_reg_write=0, wb_valid=0, misalign_err=0, err_count=0.
  - RAM contents are not cleared.
  - A store presented during the reset cycle is not performed.
- Accept condition: accept = in_valid & ~stall & ~flush & ~reset.
- RAM:
  - Word index = alu_result[DMEM_AW+1:2]. Upper address bits are ignored, so the address wraps modulo RAM size.
  - Read is combinational from the array.
  - Write occurs at the clock edge only when accept & mem_write & aligned.
- Alignment:
  - Half requires alu_result[0]=0; word requires alu_result[1:0]=0; byte is always aligned.
  - Misaligned accepted load or store: no RAM write, latched wb_reg_write=0, wb_valid=1, misalign_err=1 for that slot, err_count increments and saturates at 255.
- Stores: byte lane = alu_result[1:0], half lane = alu_result[1]. Only the selected lanes change, using the low bits of store_data. A store never writes the register file.
- Load extraction: select the byte/half lane, then zero- or sign-extend to DATA_W per load_signed. A word load returns the full word.
- Latency:
  - 1 cycle. Accepted at edge N → outMuxWb, wb_rd, wb_reg_write valid after edge N.
  - outMuxWb = latched mem_to_reg ? latched load data : latched alu_result. The mux is driven from registered fields only; there is no combinational input→output path.
- Read-after-write: a load following a store to the same word on the next accepted cycle returns the new data. The store committed at the earlier edge.
- Stall (and not flush): all MEM/WB registers hold, no RAM write, err_count holds.
- Flush (priority over stall):
  - MEM/WB loads a bubble: wb_valid=0, wb_reg_write=0, misalign_err=0.
  - outMuxWb and wb_rd hold their previous values.
  - No RAM write.
- in_valid=0 with no stall: same bubble load as flush.
- mem_read & mem_write both set: treated as a store. The latched result forces wb_reg_write=0.

Optional Feature:
- Macro: MEM_SUBWORD_EN.
- Defined: byte/half accesses as specified above.
- Undefined:
  - size and load_signed are ignored; every access is a word access.
  - Alignment check is alu_result[1:0]=0 only.
  - Stores write all lanes.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word 0x10 with mem_to_reg=1, rd=5 → outMuxWb=0xDEADBEEF, wb_rd=5, wb_reg_write=1 one cycle after the load is accepted.
- ALU op alu_result=0x1234, reg_write=1, mem_to_reg=0, rd=3 → outMuxWb=0x1234 next cycle, RAM unchanged.
- Sub-word (MEM_SUBWORD_EN): store byte 0x80 at 0x13 over 0x00000000 → word reads 0x80000000.
  - Signed byte load of 0x13 → 0xFFFFFF80.
  - Unsigned half load of 0x12 → 0x00008000.
- Misaligned word load at 0x22 → misalign_err=1 for 1 cycle, wb_reg_write=0, err_count=1.
  - Repeat 300 times → err_count=255.
- Store to 0x40 with stall=1 for 3 cycles then stall=0 → exactly one RAM write, MEM/WB outputs frozen during stall.
  - Same store with flush=1 → RAM at 0x40 unchanged, wb_valid=0.
- Reset asserted in the same cycle as an accepted store to 0x08 → RAM at 0x08 unchanged, all outputs 0 next cycle.
